// File: rtl/imem_loader.sv
// imem_loader: packs a host byte stream (high byte first) into 16-bit words
// and writes them to instruction memory at consecutive even byte addresses.
// A load ends on an HLT opcode word or when the top address has been written.
module imem_loader #(
   parameter logic [15:0] BASE_ADDR = 16'h0000,
   parameter logic [3:0]  HLT_OPC   = 4'hF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        abort,
   input  logic [7:0]  byte_in,
   input  logic        byte_valid,
   output logic        byte_ready,
   output logic [15:0] mem_addr,
   output logic [15:0] mem_data,
   output logic        mem_wr,
   output logic        busy,
   output logic        done,
   output logic        hlt_seen,
   output logic        err_overflow,
   output logic [15:0] word_count
);

   typedef enum logic [2:0] {IDLE, HI, LO, WRITE, DONE} state_t;

   state_t     state;
   state_t     state_nxt;
   logic [7:0] hi_byte;
   logic       accept;
   logic       is_hlt;
   logic       at_top;

   // Word being written carries the HLT opcode / sits at the last even address.
   assign is_hlt = (mem_data[15:12] == HLT_OPC);
   assign at_top = (mem_addr == 16'hFFFE);

   // Next-state logic and the combinational handshake/status outputs.
   always_comb begin
      // NOTE: every signal assigned here gets a default first so no path
      // through the case statement can leave it unassigned and infer a latch.
      state_nxt  = state;
      byte_ready = ((state == HI) || (state == LO)) && !abort && !rst;
      accept     = byte_ready && byte_valid;
      mem_wr     = (state == WRITE) && !rst;
      busy       = (state == HI) || (state == LO) || (state == WRITE);
      done       = (state == DONE);

      case (state)
         IDLE, DONE: begin
            if (start) state_nxt = HI;
         end
         HI: begin
            if (abort)       state_nxt = IDLE;
            else if (accept) state_nxt = LO;
         end
         LO: begin
            if (abort)       state_nxt = IDLE;
            else if (accept) state_nxt = WRITE;
         end
         WRITE: begin
            // abort is deliberately not looked at: a started write completes.
            if (is_hlt || at_top) state_nxt = DONE;
            else                  state_nxt = HI;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State register; rst wins over every other input.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all flops
      // update together at the edge regardless of statement order.
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Datapath: byte latch, write word, address, count and termination flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         mem_addr     <= BASE_ADDR;
         mem_data     <= 16'h0000;
         hi_byte      <= 8'h00;
         word_count   <= 16'h0000;
         hlt_seen     <= 1'b0;
         err_overflow <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  mem_addr     <= BASE_ADDR;
                  word_count   <= 16'h0000;
                  hlt_seen     <= 1'b0;
                  err_overflow <= 1'b0;
               end
            end
            HI: begin
               if (accept) hi_byte <= byte_in;
            end
            LO: begin
               // The assembled word only appears on mem_data once it is
               // actually being written, so a discarded half-word never shows.
               if (accept) mem_data <= {hi_byte, byte_in};
            end
            WRITE: begin
               if (word_count != 16'hFFFF) word_count <= word_count + 16'd1;
               if (is_hlt)      hlt_seen     <= 1'b1;
               else if (at_top) err_overflow <= 1'b1;
               else             mem_addr     <= mem_addr + 16'd2;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed plus randomized loads against a word-list model.
// Two instances share the stimulus: dut_a at base 0, dut_b at 16'hFFFC for
// the address-exhaustion cases.
module tb_imem_loader;

   typedef logic [7:0] byteq_t[$];

   logic        clk = 1'b0;
   logic        rst, start, abort, byte_valid;
   logic [7:0]  byte_in;

   logic        a_ready, a_wr, a_busy, a_done, a_hlt, a_ovf;
   logic [15:0] a_addr, a_data, a_wc;
   logic        b_ready, b_wr, b_busy, b_done, b_hlt, b_ovf;
   logic [15:0] b_addr, b_data, b_wc;

   logic        sel;  // 0: observe dut_a, 1: observe dut_b
   logic        cur_ready, cur_wr, cur_busy, cur_done, cur_hlt, cur_ovf;
   logic [15:0] cur_addr, cur_data, cur_wc, cur_base;

   logic [31:0] log_a[$];
   logic [31:0] log_b[$];
   logic [31:0] exp_q[$];
   logic        exp_hlt, exp_ovf;

   int n_checks = 0;
   int n_fail   = 0;

   imem_loader #(.BASE_ADDR(16'h0000), .HLT_OPC(4'hF)) dut_a (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(a_ready),
      .mem_addr(a_addr), .mem_data(a_data), .mem_wr(a_wr),
      .busy(a_busy), .done(a_done), .hlt_seen(a_hlt),
      .err_overflow(a_ovf), .word_count(a_wc)
   );

   imem_loader #(.BASE_ADDR(16'hFFFC), .HLT_OPC(4'hF)) dut_b (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(b_ready),
      .mem_addr(b_addr), .mem_data(b_data), .mem_wr(b_wr),
      .busy(b_busy), .done(b_done), .hlt_seen(b_hlt),
      .err_overflow(b_ovf), .word_count(b_wc)
   );

   assign cur_ready = sel ? b_ready : a_ready;
   assign cur_wr    = sel ? b_wr    : a_wr;
   assign cur_busy  = sel ? b_busy  : a_busy;
   assign cur_done  = sel ? b_done  : a_done;
   assign cur_hlt   = sel ? b_hlt   : a_hlt;
   assign cur_ovf   = sel ? b_ovf   : a_ovf;
   assign cur_addr  = sel ? b_addr  : a_addr;
   assign cur_data  = sel ? b_data  : a_data;
   assign cur_wc    = sel ? b_wc    : a_wc;
   assign cur_base  = sel ? 16'hFFFC : 16'h0000;

   always #5 clk = ~clk;

   // Record every write strobe mid-cycle, away from the active edge.
   always @(negedge clk) begin
      if (a_wr) log_a.push_back({a_addr, a_data});
      if (b_wr) log_b.push_back({b_addr, b_data});
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic start_pulse();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      byte_valid = 1'b1;
      byte_in    = b;
      #1;
      check("send_ready", 32'(cur_ready), 32'd1);
      step();
      byte_valid = 1'b0;
   endtask

   task automatic chk_reset(input string tag);
      check({tag, "_addr"}, 32'(cur_addr),  32'(cur_base));
      check({tag, "_data"}, 32'(cur_data),  32'd0);
      check({tag, "_wc"},   32'(cur_wc),    32'd0);
      check({tag, "_wr"},   32'(cur_wr),    32'd0);
      check({tag, "_rdy"},  32'(cur_ready), 32'd0);
      check({tag, "_busy"}, 32'(cur_busy),  32'd0);
      check({tag, "_done"}, 32'(cur_done),  32'd0);
      check({tag, "_hlt"},  32'(cur_hlt),   32'd0);
      check({tag, "_ovf"},  32'(cur_ovf),   32'd0);
   endtask

   // Reference: pair the stream into words at base, base+2, ... and stop
   // after the first HLT word or after the word written at 16'hFFFE.
   function automatic void model(input logic [15:0] base, input byteq_t b);
      logic [15:0] w, a;
      exp_q.delete();
      exp_hlt = 1'b0;
      exp_ovf = 1'b0;
      for (int i = 0; i + 1 < b.size(); i += 2) begin
         w = {b[i], b[i+1]};
         a = base + 16'(i);
         exp_q.push_back({a, w});
         if (w[15:12] == 4'hF) begin exp_hlt = 1'b1; break; end
         if (a == 16'hFFFE)    begin exp_ovf = 1'b1; break; end
      end
   endfunction

   task automatic cmp_log(input string tag);
      logic [31:0] got[$];
      got = sel ? log_b : log_a;
      check({tag, "_nwrites"}, 32'(got.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < got.size(); i++)
         check({tag, "_write"}, got[i], exp_q[i]);
   endtask

   // Start a load and feed the stream until the observed DUT leaves busy.
   task automatic run_load(input string tag, input byteq_t b, input int valid_pct,
                           input int stall_idx, input int stall_len, input bit noisy);
      int idx   = 0;
      int cyc   = 0;
      int stall = 0;
      logic acc;
      model(cur_base, b);
      log_a.delete();
      log_b.delete();
      start_pulse();
      check({tag, "_st_busy"}, 32'(cur_busy), 32'd1);
      check({tag, "_st_done"}, 32'(cur_done), 32'd0);
      check({tag, "_st_hlt"},  32'(cur_hlt),  32'd0);
      check({tag, "_st_ovf"},  32'(cur_ovf),  32'd0);
      check({tag, "_st_wc"},   32'(cur_wc),   32'd0);
      check({tag, "_st_addr"}, 32'(cur_addr), 32'(cur_base));
      while (cur_busy && cyc < 2000) begin
         if (idx == stall_idx && stall < stall_len) begin
            byte_valid = 1'b0;
            stall++;
            #1;
            check({tag, "_stall_rdy"}, 32'(cur_ready), 32'd1);
         end else begin
            byte_valid = (idx < b.size()) && ($urandom_range(99) < valid_pct);
            #1;
         end
         byte_in = byte_valid ? b[idx] : 8'($urandom);
         start   = noisy && ($urandom_range(3) == 0);
         #1;
         acc = byte_valid && cur_ready;
         if (cur_wr) check({tag, "_rdy_in_wr"}, 32'(cur_ready), 32'd0);
         step();
         cyc++;
         if (acc) begin
            idx++;
            if (idx % 2 == 0 && (idx / 2) <= exp_q.size()) begin
               check({tag, "_wr_now"}, 32'(cur_wr), 32'd1);
               check({tag, "_wr_word"}, {cur_addr, cur_data}, exp_q[idx/2 - 1]);
            end
         end
      end
      byte_valid = 1'b0;
      start      = 1'b0;
      if (cyc >= 2000) check({tag, "_timeout"}, 32'd1, 32'd0);
      step();
      cmp_log(tag);
      check({tag, "_accepted"}, 32'(idx),      32'(2 * exp_q.size()));
      check({tag, "_done"},     32'(cur_done), 32'd1);
      check({tag, "_busy"},     32'(cur_busy), 32'd0);
      check({tag, "_hlt"},      32'(cur_hlt),  32'(exp_hlt));
      check({tag, "_ovf"},      32'(cur_ovf),  32'(exp_ovf));
      check({tag, "_wc"},       32'(cur_wc),   32'(exp_q.size()));
   endtask

   function automatic byteq_t rand_stream(input int n_words, input bit end_hlt);
      byteq_t q;
      logic [15:0] w;
      for (int i = 0; i < n_words; i++) begin
         w = 16'($urandom);
         if (w[15:12] == 4'hF) w[15:12] = 4'($urandom_range(14));
         if (end_hlt && i == n_words - 1) w[15:12] = 4'hF;
         q.push_back(w[15:8]);
         q.push_back(w[7:0]);
      end
      return q;
   endfunction

   initial begin
      byteq_t s;
      rst = 1'b1; start = 1'b0; abort = 1'b0; byte_valid = 1'b0; byte_in = 8'h00;
      sel = 1'b0;
      step();
      step();
      rst = 1'b0;
      #1;
      chk_reset("reset_a");
      sel = 1'b1;
      #1;
      chk_reset("reset_b");
      sel = 1'b0;
      #1;

      // Basic load, byte_valid held high.
      s = '{8'h12, 8'h34, 8'hA5, 8'h67, 8'hF0, 8'h00};
      run_load("basic", s, 100, -1, 0, 1'b0);

      // abort in DONE has no effect.
      abort = 1'b1;
      step();
      abort = 1'b0;
      #1;
      check("abort_done", 32'(cur_done), 32'd1);

      // Restart from DONE.
      s = '{8'hB1, 8'h23, 8'hF0, 8'h00};
      run_load("restart", s, 100, -1, 0, 1'b0);

      // Sender stalls 4 cycles between the bytes of word 2.
      s = '{8'h12, 8'h34, 8'hA5, 8'h67, 8'hF0, 8'h00};
      run_load("stall", s, 100, 3, 4, 1'b0);

      // Abort mid-word while in LO.
      log_a.delete();
      start_pulse();
      send_byte(8'h00);
      send_byte(8'h11);
      byte_valid = 1'b1;
      byte_in    = 8'h22;
      #1;
      check("abt_wr",   32'(cur_wr),    32'd1);
      check("abt_rdy",  32'(cur_ready), 32'd0);
      check("abt_word", {cur_addr, cur_data}, {16'h0000, 16'h0011});
      step();
      send_byte(8'h22);
      abort      = 1'b1;
      byte_valid = 1'b1;
      byte_in    = 8'h33;
      #1;
      check("abt_lo_rdy", 32'(cur_ready), 32'd0);
      step();
      abort      = 1'b0;
      byte_valid = 1'b0;
      step();
      check("abt_busy", 32'(cur_busy),      32'd0);
      check("abt_done", 32'(cur_done),      32'd0);
      check("abt_wc",   32'(cur_wc),        32'd1);
      check("abt_nwr",  32'(log_a.size()),  32'd1);

      // abort in IDLE does nothing; start with abort in IDLE wins.
      abort = 1'b1;
      step();
      check("abt_idle", 32'(cur_busy), 32'd0);
      start = 1'b1;
      step();
      start = 1'b0;
      abort = 1'b0;
      check("start_wins_busy", 32'(cur_busy), 32'd1);
      check("start_wins_wc",   32'(cur_wc),   32'd0);

      // abort during WRITE is ignored.
      send_byte(8'h01);
      send_byte(8'h02);
      abort = 1'b1;
      #1;
      check("abt_wr_strobe", 32'(cur_wr), 32'd1);
      step();
      check("abt_wr_busy", 32'(cur_busy), 32'd1);
      check("abt_wr_addr", 32'(cur_addr), 32'h0002);
      check("abt_wr_wc",   32'(cur_wc),   32'd1);
      step();
      abort = 1'b0;
      check("abt_hi_idle", 32'(cur_busy), 32'd0);

      // Reset while in LO.
      log_a.delete();
      start_pulse();
      send_byte(8'hAB);
      rst        = 1'b1;
      byte_valid = 1'b1;
      byte_in    = 8'hCD;
      #1;
      check("rst_rdy", 32'(cur_ready), 32'd0);
      step();
      rst        = 1'b0;
      byte_valid = 1'b0;
      chk_reset("rst_mid");
      step();
      check("rst_nwr", 32'(log_a.size()), 32'd0);
      s = '{8'hF0, 8'h00};
      run_load("after_rst", s, 100, -1, 0, 1'b0);

      // Randomized loads with sender gaps and stray start pulses.
      for (int t = 0; t < 6; t++) begin
         s = rand_stream($urandom_range(1, 8), 1'b1);
         run_load("rand", s, $urandom_range(30, 100), -1, 0, 1'b1);
      end

      // Address exhaustion on the high-base instance.
      rst = 1'b1;
      step();
      rst = 1'b0;
      sel = 1'b1;
      #1;
      chk_reset("reset_b2");
      s = '{8'h00, 8'h01, 8'h00, 8'h02, 8'h00, 8'h03};
      run_load("ovf", s, 100, -1, 0, 1'b0);
      for (int t = 0; t < 3; t++) begin
         s = rand_stream($urandom_range(2, 4), 1'b0);
         run_load("rand_ovf", s, $urandom_range(30, 100), -1, 0, 1'b1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the instruction path: takes a byte stream from the host or test port and packs it into 16-bit instruction words.
- Writes the words into instruction memory at consecutive byte addresses, so the fetch/decode stage can later read and decode them.
- Inspects bits [15:12] of each assembled word and ends the load on the HLT opcode 4'hF.
- Sits between the external load interface and the instruction memory write port. Only active while the core is held off.

Parameters:
BASE_ADDR, 16'h0000, byte address of the first instruction word written (must be even)
HLT_OPC, 4'hF, opcode value in bits [15:12] that terminates a load

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
start  input  1  single-cycle pulse; begins a load
abort  input  1  cancels a load in progress
byte_in  input  8  incoming instruction byte, high byte of each word first
byte_valid  input  1  byte_in holds a valid byte
byte_ready  output  1  loader accepts byte_in this cycle
mem_addr  output  16  instruction memory byte address
mem_data  output  16  instruction word to write
mem_wr  output  1  memory write strobe, one cycle per word
busy  output  1  load in progress
done  output  1  load finished; held until the next start or rst
hlt_seen  output  1  load ended on an HLT word
err_overflow  output  1  load ended by address space exhaustion
word_count  output  16  number of words written in the current load

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - state=IDLE.
  - mem_addr=BASE_ADDR; mem_data, word_count and the byte latch cleared to 0.
  - mem_wr, byte_ready, busy, done, hlt_seen and err_overflow all 0.
  - rst overrides every other input.
  - rst mid-load discards any partial word; no write is issued in that cycle.
- FSM states: IDLE, HI, LO, WRITE, DONE.
- IDLE:
  - start=1 -> HI.
  - On that transition: mem_addr=BASE_ADDR, word_count=0, done, hlt_seen and err_overflow cleared.
- HI:
  - byte_valid & byte_ready -> latch byte_in as bits [15:8], go to LO.
- LO:
  - byte_valid & byte_ready -> latch byte_in as bits [7:0], go to WRITE.
- WRITE (exactly one cycle):
  - mem_wr=1, mem_data={hi,lo}, mem_addr=current address; word_count increments at the end of the cycle.
  - If mem_data[15:12]==HLT_OPC -> DONE, set hlt_seen. The HLT word itself is written and counted.
  - Else if mem_addr==16'hFFFE -> DONE, set err_overflow. mem_addr does not wrap.
  - Else mem_addr += 2, go to HI.
- DONE:
  - done=1. start=1 restarts exactly as from IDLE: it clears flags and count and goes to HI.
- byte_ready = (state==HI || state==LO) & ~abort & ~rst, driven combinationally.
  - A byte transfers only on a cycle where byte_valid and byte_ready are both 1.
  - byte_valid with byte_ready=0 has no effect; the sender holds the byte.
- busy = 1 in HI, LO and WRITE.
- Latency:
  - The write occurs in the cycle after the low byte is accepted.
  - Minimum spacing is 3 cycles per word (HI, LO, WRITE).
  - byte_ready=0 during WRITE.
- abort:
  - In HI or LO -> IDLE. The partial word is discarded, no write, done stays 0, and word_count keeps the words already written.
  - In WRITE, abort is ignored; the write and its transition complete.
  - In IDLE or DONE, abort has no effect.
- start while busy is ignored. start together with abort in IDLE: start wins.
- mem_wr never asserts outside WRITE. mem_addr and mem_data hold their last values otherwise.
- word_count saturates at 16'hFFFF. This is unreachable when BASE_ADDR=0, since the maximum is 32768 words.

Test Plan:
- Basic load:
  - Stimulus: start, then bytes 12 34 A5 67 F0 00 with byte_valid held high.
  - Required response:
    - Writes 16'h1234@0x0000, 16'hA567@0x0002, 16'hF000@0x0004, each as a single mem_wr pulse 3 cycles apart.
    - Ends with done=1, hlt_seen=1, word_count=3, busy=0.
- Sender stalls:
  - Stimulus: same stream with byte_valid low for 4 cycles between the high and low bytes of word 2.
  - Required response: the same three writes and no spurious mem_wr; byte_ready drops only in WRITE.
- Abort mid-word:
  - Stimulus: start, bytes 00 11 22, then abort for 1 cycle while in LO, with byte_valid=1 on the abort cycle.
  - Required response: one write (16'h0011@0x0000), byte not consumed, state IDLE, word_count=1, done=0.
- Overflow:
  - Stimulus: BASE_ADDR=16'hFFFC, start, bytes 00 01 00 02 00 03.
  - Required response: writes at 0xFFFC and 0xFFFE, then done=1, err_overflow=1, hlt_seen=0, word_count=2. Byte 00 03 is not accepted.
- Reset mid-operation:
  - Stimulus: rst pulsed while in LO.
  - Required response: next cycle has all outputs at their reset values, mem_addr=BASE_ADDR, and no mem_wr. A following start plus bytes F0 00 writes 16'hF000@BASE_ADDR.
- Restart from DONE:
  - Stimulus: after a completed load, start again with bytes B1 23 F0 00.
  - Required response: flags cleared on start, writes 16'hB123@BASE_ADDR and 16'hF000@BASE_ADDR+2, word_count=2.
